// File: rtl/pwm_signal_decoder_pkg.sv
// =====================================================================
// pwm_pkg: shared states and default widths for the PWM signal decoder
// Rev 1.0
// =====================================================================
`default_nettype none

package pwm_pkg;

  localparam int c_DEFAULT_CNT_W  = 8;
  localparam int c_DEFAULT_DUTY_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DIVIDE  = 2'd2
  } pwm_state_e;

endpackage

`default_nettype wire

// File: rtl/pwm_signal_decoder_if.sv
// =====================================================================
// pwm_signal_decoder_if: PWM input, enable and measurement result bundle
// Rev 1.0
// =====================================================================
`default_nettype none

interface pwm_signal_decoder_if
  import pwm_pkg::*;
#(
  parameter int CNT_W  = c_DEFAULT_CNT_W,
  parameter int DUTY_W = c_DEFAULT_DUTY_W
) ();

  logic              ena;
  logic              pwm_in;
  logic [CNT_W-1:0]  period;
  logic [CNT_W-1:0]  high_time;
  logic [DUTY_W-1:0] duty;
  logic              valid;
  logic              stuck;

  modport master (
    output ena,
    output pwm_in,
    input  period,
    input  high_time,
    input  duty,
    input  valid,
    input  stuck
  );

  modport slave (
    input  ena,
    input  pwm_in,
    output period,
    output high_time,
    output duty,
    output valid,
    output stuck
  );

endinterface

`default_nettype wire

// File: rtl/pwm_signal_decoder_div.sv
// =====================================================================
// pwm_duty_div: sequential restoring divider producing the duty code
// Rev 1.0
// =====================================================================
`default_nettype none

module pwm_duty_div
  import pwm_pkg::*;
#(
  parameter int CNT_W  = c_DEFAULT_CNT_W,
  parameter int DUTY_W = c_DEFAULT_DUTY_W
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              start,
  input  wire logic [CNT_W-1:0]  dividend,
  input  wire logic [CNT_W-1:0]  divisor,
  output logic                   done,
  output logic [DUTY_W-1:0]      quotient
);

  localparam int c_STEP_W = (DUTY_W > 1) ? $clog2(DUTY_W) : 1;
  localparam logic [c_STEP_W-1:0] c_LAST_STEP = c_STEP_W'(DUTY_W - 1);

  logic [CNT_W:0]      r_rem;
  logic [CNT_W-1:0]    r_div;
  logic [DUTY_W-1:0]   r_quo;
  logic [c_STEP_W-1:0] r_step;
  logic                r_busy;
  logic                r_sat;

  logic [CNT_W:0]      w_shift;
  logic                w_ge;
  logic [CNT_W:0]      w_rem_next;
  logic [DUTY_W:0]     w_quo_wide;
  logic [DUTY_W-1:0]   w_quo_next;
  logic                w_last;

  // A set top bit means the doubled remainder already exceeds any divisor.
  always_comb begin
    w_shift    = {r_rem[CNT_W-1:0], 1'b0};
    w_ge       = r_rem[CNT_W] | (w_shift >= {1'b0, r_div});
    w_rem_next = w_ge ? (w_shift - {1'b0, r_div}) : w_shift;
    w_quo_wide = {r_quo, w_ge};
    w_quo_next = w_quo_wide[DUTY_W-1:0];
    w_last     = r_busy && (r_step == c_LAST_STEP);
  end

  assign done     = w_last;
  assign quotient = r_sat ? '1 : w_quo_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem  <= '0;
      r_div  <= '0;
      r_quo  <= '0;
      r_step <= '0;
      r_busy <= 1'b0;
      r_sat  <= 1'b0;
    end else if (start) begin
      r_rem  <= {1'b0, dividend};
      r_div  <= divisor;
      r_quo  <= '0;
      r_step <= '0;
      r_busy <= 1'b1;
      r_sat  <= (dividend >= divisor);
    end else if (r_busy) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
      if (w_last) begin
        r_busy <= 1'b0;
      end else begin
        r_step <= r_step + c_STEP_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pwm_signal_decoder.sv
// =====================================================================
// pwm_signal_decoder: measures PWM period, high time and duty code
// Rev 1.0
// =====================================================================
`default_nettype none

module pwm_signal_decoder
  import pwm_pkg::*;
#(
  parameter int CNT_W  = c_DEFAULT_CNT_W,
  parameter int DUTY_W = c_DEFAULT_DUTY_W
) (
  input  wire logic           clk,
  input  wire logic           rst,
  pwm_signal_decoder_if.slave bus
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  pwm_state_e r_state;
  pwm_state_e w_state_next;

  logic              r_sync1;
  logic              r_s;
  logic              r_s_d;
  logic              w_rise;

  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_hcnt;
  logic              w_cnt_max;

  logic [CNT_W-1:0]  r_per_op;
  logic [CNT_W-1:0]  r_high_op;

  logic              w_capture;
  logic              w_commit;
  logic              w_stuck_evt;
  logic              w_div_done;
  logic [DUTY_W-1:0] w_div_quo;

  logic [CNT_W-1:0]  r_period;
  logic [CNT_W-1:0]  r_high_time;
  logic [DUTY_W-1:0] r_duty;
  logic              r_valid;
  logic              r_stuck;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_s     <= 1'b0;
      r_s_d   <= 1'b0;
    end else begin
      r_sync1 <= bus.pwm_in;
      r_s     <= r_sync1;
      r_s_d   <= r_s;
    end
  end

  assign w_rise    = r_s & ~r_s_d;
  assign w_cnt_max = (r_cnt == c_CNT_MAX);

  // The rising-edge cycle itself is the first cycle of the new period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_hcnt <= '0;
    end else if (!bus.ena) begin
      r_cnt  <= '0;
      r_hcnt <= '0;
    end else if (w_rise) begin
      r_cnt  <= {{(CNT_W-1){1'b0}}, 1'b1};
      r_hcnt <= {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      if (!w_cnt_max) begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (r_hcnt != c_CNT_MAX) begin
        r_hcnt <= r_hcnt + {{(CNT_W-1){1'b0}}, r_s};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_commit     = 1'b0;
    w_stuck_evt  = 1'b0;
    if (!bus.ena) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            w_state_next = ST_MEASURE;
          end else if (w_cnt_max && !r_stuck) begin
            w_stuck_evt = 1'b1;
          end
        end
        ST_MEASURE: begin
          // A saturated count is not a valid period, even if an edge lands now.
          if (w_cnt_max) begin
            w_stuck_evt  = !r_stuck;
            w_state_next = ST_IDLE;
          end else if (w_rise) begin
            w_capture    = 1'b1;
            w_state_next = ST_DIVIDE;
          end
        end
        ST_DIVIDE: begin
          if (w_div_done) begin
            w_commit     = 1'b1;
            w_state_next = ST_MEASURE;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_per_op  <= '0;
      r_high_op <= '0;
    end else if (w_capture) begin
      r_per_op  <= r_cnt;
      r_high_op <= r_hcnt;
    end
  end

  pwm_duty_div #(
    .CNT_W  (CNT_W),
    .DUTY_W (DUTY_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (w_capture),
    .dividend (r_hcnt),
    .divisor  (r_cnt),
    .done     (w_div_done),
    .quotient (w_div_quo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period    <= '0;
      r_high_time <= '0;
      r_duty      <= '0;
      r_valid     <= 1'b0;
      r_stuck     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_commit) begin
        r_period    <= r_per_op;
        r_high_time <= r_high_op;
        r_duty      <= w_div_quo;
        r_valid     <= 1'b1;
        r_stuck     <= 1'b0;
      end else if (w_stuck_evt) begin
        r_period    <= '0;
        r_high_time <= '0;
        r_duty      <= r_s ? '1 : '0;
        r_valid     <= 1'b1;
        r_stuck     <= 1'b1;
      end
    end
  end

  assign bus.period    = r_period;
  assign bus.high_time = r_high_time;
  assign bus.duty      = r_duty;
  assign bus.valid     = r_valid;
  assign bus.stuck     = r_stuck;

endmodule

`default_nettype wire
